// File: rtl/cdecv_pkg.sv
// CDECv sequencer shared definitions: state codes, opcode classes,
// bus/write-enable indices, ALU op and jump condition codes.
package cdecv_pkg;

    typedef enum logic [11:0] {
        S_R    = 12'h000,
        S_F0   = 12'h010,
        S_F1   = 12'h011,
        S_F2   = 12'h012,
        S_MOV0 = 12'h020,
        S_ALU0 = 12'h030,
        S_ALU1 = 12'h031,
        S_ALU2 = 12'h032,
        S_LD0  = 12'h040,
        S_LD1  = 12'h041,
        S_LD2  = 12'h042,
        S_LD3  = 12'h043,
        S_LD4  = 12'h044,
        S_ST0  = 12'h050,
        S_ST1  = 12'h051,
        S_ST2  = 12'h052,
        S_ST3  = 12'h053,
        S_ST4  = 12'h054,
        S_J0   = 12'h060,
        S_J1   = 12'h061,
        S_J2   = 12'h062,
        S_HALT = 12'h070,
        S_ILL  = 12'h0FF
    } state_e;

    localparam logic [3:0] OP_MOV = 4'h0;
    localparam logic [3:0] OP_CMP = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] XS_PC  = 3'd0;
    localparam logic [2:0] XS_RD  = 3'd4;
    localparam logic [2:0] XS_R   = 3'd5;
    localparam logic [2:0] XS_FF  = 3'd7;

    localparam int XD_PC  = 0;
    localparam int XD_MA  = 4;
    localparam int XD_WD  = 5;
    localparam int XD_I   = 6;
    localparam int XD_T   = 7;
    localparam int XD_R   = 8;
    localparam int XD_FLG = 9;

    // ALU opcodes 1..7 reuse the instruction class number directly
    localparam logic [4:0] ALU_PASS = 5'd0;
    localparam logic [4:0] ALU_INC  = 5'd8;

    localparam logic [2:0] CC_ALW = 3'd0;
    localparam logic [2:0] CC_S   = 3'd1;
    localparam logic [2:0] CC_Z   = 3'd2;
    localparam logic [2:0] CC_CY  = 3'd3;

    function automatic logic is_alu(input logic [3:0] op);
        return (op != OP_MOV) && (op <= OP_SHL);
    endfunction

    function automatic logic legal(input logic [7:0] ir);
        logic ok;
        unique case (ir[7:4])
            OP_LD:   ok = (ir[3:2] == 2'b00);
            OP_ST:   ok = (ir[1:0] == 2'b00);
            OP_JMP:  ok = (ir[2] == 1'b0);
            OP_HLT:  ok = (ir[3:0] == 4'hF);
            default: ok = (ir[7:4] <= OP_SHL);
        endcase
        return ok;
    endfunction

    // I must still describe the instruction whose microsequence is running
    function automatic logic fits(input state_e s, input logic [7:0] ir);
        logic mid;
        logic grp;
        mid = 1'b1;
        grp = 1'b0;
        unique case (s)
            S_MOV0: grp = (ir[7:4] == OP_MOV);
            S_ALU0, S_ALU1, S_ALU2:
                grp = is_alu(ir[7:4]);
            S_LD0, S_LD1, S_LD2, S_LD3, S_LD4:
                grp = (ir[7:4] == OP_LD);
            S_ST0, S_ST1, S_ST2, S_ST3, S_ST4:
                grp = (ir[7:4] == OP_ST);
            S_J0, S_J1, S_J2:
                grp = (ir[7:4] == OP_JMP);
            default: mid = 1'b0;
        endcase
        return !mid || (grp && legal(ir));
    endfunction

    function automatic logic cond_ok(input logic [3:0] lo, input logic [2:0] f);
        logic c;
        unique case (lo[2:0])
            CC_ALW:  c = 1'b1;
            CC_S:    c = f[2];
            CC_Z:    c = f[1];
            CC_CY:   c = f[0];
            default: c = 1'b0;
        endcase
        return c ^ lo[3];
    endfunction

endpackage

// File: rtl/ucode_decoder.sv
// Microcode decode: purely combinational (state, I, flags) to
// bus source, write enables, ALU op, memory write and end-of-sequence.
module ucode_decoder
    import cdecv_pkg::*;
#(
    parameter int FW      = 3,
    parameter int XSRC_W  = 3,
    parameter int XDST_W  = 10,
    parameter int ALUOP_W = 5
) (
    input  state_e              state,
    input  logic [7:0]          ir,
    input  logic [FW-1:0]       szcy,
    output logic [XSRC_W-1:0]   xsrc,
    output logic [XDST_W-1:0]   xdst,
    output logic [ALUOP_W-1:0]  aluop,
    output logic                we,
    output logic                end_sq
);

    logic [2:0] xs_c;
    logic [9:0] xd_c;
    logic [4:0] op_c;
    logic [1:0] ss;
    logic [1:0] dd;

    assign ss = ir[3:2];
    assign dd = ir[1:0];

    always_comb begin
        xs_c   = XS_FF;
        xd_c   = '0;
        op_c   = ALU_PASS;
        we     = 1'b0;
        end_sq = 1'b0;
        unique case (state)
            S_F0, S_LD0, S_ST0, S_J0: begin
                xs_c        = XS_PC;
                xd_c[XD_MA] = 1'b1;
            end
            S_F1, S_LD1, S_ST1: begin
                xs_c        = XS_PC;
                op_c        = ALU_INC;
                xd_c[XD_PC] = 1'b1;
            end
            S_F2: begin
                xs_c       = XS_RD;
                xd_c[XD_I] = 1'b1;
            end
            S_MOV0: begin
                xs_c           = {1'b0, ss};
                xd_c[4'(dd)]   = 1'b1;
                end_sq         = 1'b1;
            end
            S_ALU0: begin
                xs_c       = {1'b0, dd};
                xd_c[XD_T] = 1'b1;
            end
            S_ALU1: begin
                xs_c         = {1'b0, ss};
                op_c         = {1'b0, ir[7:4]};
                xd_c[XD_R]   = 1'b1;
                xd_c[XD_FLG] = 1'b1;
                end_sq       = (ir[7:4] == OP_CMP);
            end
            S_ALU2: begin
                xs_c         = XS_R;
                xd_c[4'(dd)] = 1'b1;
                end_sq       = 1'b1;
            end
            S_LD2, S_ST2: begin
                xs_c        = XS_RD;
                xd_c[XD_MA] = 1'b1;
            end
            S_LD4: begin
                xs_c         = XS_RD;
                xd_c[4'(dd)] = 1'b1;
                end_sq       = 1'b1;
            end
            S_ST3: begin
                xs_c        = {1'b0, ss};
                xd_c[XD_WD] = 1'b1;
            end
            S_ST4: begin
                we     = 1'b1;
                end_sq = 1'b1;
            end
            S_J2: begin
                xd_c[XD_PC] = 1'b1;
                end_sq      = 1'b1;
                // not taken: step PC over the operand byte
                if (cond_ok(ir[3:0], szcy[2:0])) begin
                    xs_c = XS_RD;
                end else begin
                    xs_c = XS_PC;
                    op_c = ALU_INC;
                end
            end
            default: ;
        endcase
    end

    assign xsrc  = XSRC_W'(xs_c);
    assign xdst  = XDST_W'(xd_c);
    assign aluop = ALUOP_W'(op_c);

endmodule

// File: rtl/seq_controller.sv
// CDECv control sequencer: state register, next-state logic,
// single-step/run/reset gating and monitor status outputs.
module seq_controller
    import cdecv_pkg::*;
#(
    parameter int IW      = 8,
    parameter int FW      = 3,
    parameter int XSRC_W  = 3,
    parameter int XDST_W  = 10,
    parameter int ALUOP_W = 5,
    parameter int STATE_W = 12
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [IW-1:0]       I,
    input  logic [FW-1:0]       SZCy,
    input  logic                run,
    input  logic                step_en,
    output logic [XSRC_W-1:0]   xsrc,
    output logic [XDST_W-1:0]   xdst,
    output logic [ALUOP_W-1:0]  aluop,
    output logic                we,
    output logic                end_sq,
    output logic                pause_cc,
    output logic [STATE_W-1:0]  state_o,
    output logic                halted,
    output logic                illegal
);

    state_e             state_q;
    state_e             state_d;
    logic   [7:0]       ir;
    logic   [XDST_W-1:0] dec_xdst;
    logic               dec_we;
    logic               dec_end;
    logic               gate;

    assign ir = {I[IW-1:IW-4], I[3:0]};

    always_comb begin
        state_d = state_q;
        if (step_en) begin
            unique case (state_q)
                S_R:    state_d = S_F0;
                S_F0:   state_d = S_F1;
                S_F1:   state_d = S_F2;
                S_F2: begin
                    if (!legal(ir))
                        state_d = S_ILL;
                    else if (ir[7:4] == OP_MOV)
                        state_d = S_MOV0;
                    else if (is_alu(ir[7:4]))
                        state_d = S_ALU0;
                    else if (ir[7:4] == OP_LD)
                        state_d = S_LD0;
                    else if (ir[7:4] == OP_ST)
                        state_d = S_ST0;
                    else if (ir[7:4] == OP_JMP)
                        state_d = S_J0;
                    else
                        state_d = S_HALT;
                end
                S_MOV0: state_d = S_F0;
                S_ALU0: state_d = S_ALU1;
                S_ALU1: state_d = (ir[7:4] == OP_CMP) ? S_F0 : S_ALU2;
                S_ALU2: state_d = S_F0;
                S_LD0:  state_d = S_LD1;
                S_LD1:  state_d = S_LD2;
                S_LD2:  state_d = S_LD3;
                S_LD3:  state_d = S_LD4;
                S_LD4:  state_d = S_F0;
                S_ST0:  state_d = S_ST1;
                S_ST1:  state_d = S_ST2;
                S_ST2:  state_d = S_ST3;
                S_ST3:  state_d = S_ST4;
                S_ST4:  state_d = S_F0;
                S_J0:   state_d = S_J1;
                S_J1:   state_d = S_J2;
                S_J2:   state_d = S_F0;
                S_HALT: state_d = run ? S_F0 : S_HALT;
                default: state_d = S_ILL;
            endcase
            if (!fits(state_q, ir))
                state_d = S_ILL;
        end
    end

    always_ff @(negedge clock) begin
        if (reset)
            state_q <= S_R;
        else
            state_q <= state_d;
    end

    ucode_decoder #(
        .FW      (FW),
        .XSRC_W  (XSRC_W),
        .XDST_W  (XDST_W),
        .ALUOP_W (ALUOP_W)
    ) u_dec (
        .state  (state_q),
        .ir     (ir),
        .szcy   (SZCy),
        .xsrc   (xsrc),
        .xdst   (dec_xdst),
        .aluop  (aluop),
        .we     (dec_we),
        .end_sq (dec_end)
    );

    // a held or resetting cycle must never commit a write
    assign gate     = reset || !step_en;
    assign xdst     = gate ? '0 : dec_xdst;
    assign we       = dec_we && !gate;
    assign end_sq   = dec_end && !gate;
    assign pause_cc = !step_en || (state_q == S_R)
                    || (state_q == S_HALT) || (state_q == S_ILL);
    assign state_o  = STATE_W'(state_q);
    assign halted   = (state_q == S_HALT);
    assign illegal  = (state_q == S_ILL);

endmodule

// File: tb/tb_seq_controller.sv
// Table-driven scoreboard bench for seq_controller.
// Inputs change just after the falling (active) edge; outputs are checked mid-cycle.
module tb_seq_controller;
    import cdecv_pkg::*;

    typedef struct {
        logic       rst;
        logic       stp;
        logic       run;
        logic [7:0] i;
        logic [2:0] f;
        state_e     st;
        int         xs;
        logic [9:0] xd;
        logic [9:0] xm;
        logic       we;
        int         es;
        logic       pc;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  I;
    logic [2:0]  SZCy;
    logic        run;
    logic        step_en;
    logic [2:0]  xsrc;
    logic [9:0]  xdst;
    logic [4:0]  aluop;
    logic        we;
    logic        end_sq;
    logic        pause_cc;
    logic [11:0] state_o;
    logic        halted;
    logic        illegal;

    int   checks   = 0;
    int   failures = 0;
    int   row      = 0;
    vec_t tbl[$];
    vec_t sb[$];

    always #5 clock = ~clock;

    seq_controller dut (
        .clock    (clock),
        .reset    (reset),
        .I        (I),
        .SZCy     (SZCy),
        .run      (run),
        .step_en  (step_en),
        .xsrc     (xsrc),
        .xdst     (xdst),
        .aluop    (aluop),
        .we       (we),
        .end_sq   (end_sq),
        .pause_cc (pause_cc),
        .state_o  (state_o),
        .halted   (halted),
        .illegal  (illegal)
    );

    function automatic vec_t v(
        input logic rst, input logic stp, input logic rn,
        input logic [7:0] i, input logic [2:0] f, input state_e st,
        input int xs, input logic [9:0] xd, input logic [9:0] xm,
        input logic w, input int es, input logic pc);
        vec_t t;
        t.rst = rst; t.stp = stp; t.run = rn;
        t.i = i; t.f = f; t.st = st;
        t.xs = xs; t.xd = xd; t.xm = xm;
        t.we = w; t.es = es; t.pc = pc;
        return t;
    endfunction

    function automatic vec_t n(
        input logic [7:0] i, input logic [2:0] f,
        input state_e st, input int es);
        return v(0, 1, 0, i, f, st, -1, 0, 0, 0, es, 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%0h want=%0h", nm, row, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        vec_t e;
        reset   = t.rst;
        step_en = t.stp;
        run     = t.run;
        I       = t.i;
        SZCy    = t.f;
        sb.push_back(t);
        #1;
        e = sb.pop_front();
        chk("state", 32'(state_o), 32'(e.st));
        chk("we", 32'(we), 32'(e.we));
        chk("pause_cc", 32'(pause_cc), 32'(e.pc));
        chk("halted", 32'(halted), 32'(e.st == S_HALT));
        chk("illegal", 32'(illegal), 32'(e.st == S_ILL));
        if (e.xm != 10'h0)
            chk("xdst", 32'(xdst & e.xm), 32'(e.xd & e.xm));
        if (e.xs >= 0)
            chk("xsrc", 32'(xsrc), 32'(e.xs));
        if (e.es >= 0)
            chk("end_sq", 32'(end_sq), 32'(e.es));
        row++;
        @(negedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog row=%0d", row);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; step_en = 1'b1; run = 1'b0;
        I = 8'h00; SZCy = 3'b000;
        @(negedge clock);
        #1;

        // reset, fetch, ADD B,C
        tbl.push_back(v(1,1,0,8'h00,0,S_R,-1,0,10'h3FF,0,0,1));
        tbl.push_back(v(0,1,0,8'h00,0,S_R,-1,0,10'h3FF,0,0,1));
        tbl.push_back(n(8'h16,3'b101,S_F0,0));
        tbl.push_back(n(8'h16,3'b101,S_F1,0));
        tbl.push_back(n(8'h16,3'b101,S_F2,0));
        tbl.push_back(n(8'h16,3'b101,S_ALU0,0));
        tbl.push_back(v(0,1,0,8'h16,3'b101,S_ALU1,-1,10'h200,10'h200,0,0,0));
        tbl.push_back(n(8'h16,3'b101,S_ALU2,1));
        // JZ taken
        tbl.push_back(n(8'hC2,3'b010,S_F0,0));
        tbl.push_back(n(8'hC2,3'b010,S_F1,0));
        tbl.push_back(n(8'hC2,3'b010,S_F2,0));
        tbl.push_back(n(8'hC2,3'b010,S_J0,0));
        tbl.push_back(n(8'hC2,3'b010,S_J1,0));
        tbl.push_back(v(0,1,0,8'hC2,3'b010,S_J2,4,10'h001,10'h001,0,1,0));
        // JZ not taken
        tbl.push_back(n(8'hC2,3'b000,S_F0,0));
        tbl.push_back(n(8'hC2,3'b000,S_F1,0));
        tbl.push_back(n(8'hC2,3'b000,S_F2,0));
        tbl.push_back(n(8'hC2,3'b000,S_J0,0));
        tbl.push_back(n(8'hC2,3'b000,S_J1,0));
        tbl.push_back(v(0,1,0,8'hC2,3'b000,S_J2,0,10'h001,10'h001,0,1,0));
        // CMP ends in ALU1
        tbl.push_back(n(8'h66,0,S_F0,0));
        tbl.push_back(n(8'h66,0,S_F1,0));
        tbl.push_back(n(8'h66,0,S_F2,0));
        tbl.push_back(n(8'h66,0,S_ALU0,0));
        tbl.push_back(v(0,1,0,8'h66,0,S_ALU1,-1,10'h200,10'h200,0,1,0));
        // MOV
        tbl.push_back(n(8'h05,0,S_F0,0));
        tbl.push_back(n(8'h05,0,S_F1,0));
        tbl.push_back(n(8'h05,0,S_F2,0));
        tbl.push_back(n(8'h05,0,S_MOV0,1));
        // I changes mid-ALU -> ILL, run ignored, reset recovers
        tbl.push_back(n(8'h16,0,S_F0,0));
        tbl.push_back(n(8'h16,0,S_F1,0));
        tbl.push_back(n(8'h16,0,S_F2,0));
        tbl.push_back(n(8'hC0,0,S_ALU0,0));
        tbl.push_back(v(0,1,1,8'hC0,0,S_ILL,-1,0,10'h3FF,0,0,1));
        tbl.push_back(v(1,1,0,8'hC0,0,S_ILL,-1,0,10'h3FF,0,0,1));

        foreach (tbl[k]) apply(tbl[k]);

        // HALT for 10 cycles, then run
        apply(v(0,1,0,8'hFF,0,S_R,-1,0,10'h3FF,0,0,1));
        apply(v(0,1,1,8'hFF,0,S_F0,-1,0,0,0,0,0));
        apply(n(8'hFF,0,S_F1,0));
        apply(n(8'hFF,0,S_F2,0));
        for (int k = 0; k < 10; k++)
            apply(v(0,1,0,8'hFF,0,S_HALT,-1,0,10'h3FF,0,0,1));
        apply(v(0,1,1,8'hFF,0,S_HALT,-1,0,10'h3FF,0,0,1));

        // undefined opcode traps; run cannot leave ILL
        apply(n(8'h90,0,S_F0,0));
        apply(n(8'h90,0,S_F1,0));
        apply(n(8'h90,0,S_F2,0));
        for (int k = 0; k < 2; k++)
            apply(v(0,1,1,8'h90,0,S_ILL,-1,0,10'h3FF,0,0,1));
        apply(v(1,1,0,8'h90,0,S_ILL,-1,0,10'h3FF,0,0,1));

        // ST with single-step hold in ST3
        apply(v(0,1,0,8'hA4,0,S_R,-1,0,10'h3FF,0,0,1));
        apply(n(8'hA4,0,S_F0,0));
        apply(n(8'hA4,0,S_F1,0));
        apply(n(8'hA4,0,S_F2,0));
        apply(n(8'hA4,0,S_ST0,0));
        apply(n(8'hA4,0,S_ST1,0));
        apply(n(8'hA4,0,S_ST2,0));
        for (int k = 0; k < 3; k++)
            apply(v(0,0,0,8'hA4,0,S_ST3,-1,0,10'h3FF,0,0,1));
        apply(n(8'hA4,0,S_ST3,0));
        apply(v(0,1,0,8'hA4,0,S_ST4,-1,0,0,1,1,0));

        // reset in ST4 with step_en low: no write, back to R
        apply(n(8'hA4,0,S_F0,0));
        apply(n(8'hA4,0,S_F1,0));
        apply(n(8'hA4,0,S_F2,0));
        apply(n(8'hA4,0,S_ST0,0));
        apply(n(8'hA4,0,S_ST1,0));
        apply(n(8'hA4,0,S_ST2,0));
        apply(n(8'hA4,0,S_ST3,0));
        apply(v(1,0,0,8'hA4,0,S_ST4,-1,0,10'h3FF,0,-1,1));
        apply(v(0,1,0,8'hA4,0,S_R,-1,0,10'h3FF,0,0,1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
